// File: rtl/cnn_pkg.sv
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared image geometry, pixel beat format and streamer state
//                encoding for the CNN image input path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package cnn_pkg;

    localparam int IMG_H  = 28;
    localparam int IMG_W  = 28;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = $clog2(IMG_H * IMG_W);

    // One pixel on the stream together with its frame markers.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_streamer_if.sv
// ============================================================================
//  Module      : pixel_streamer_if
//  Description : Image-memory read port plus valid/ready pixel stream with
//                frame markers. The streamer is the master; the memory and
//                the downstream datapath together form the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pixel_streamer_if #(
    parameter int PIX_W  = cnn_pkg::PIX_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

`default_nettype wire

// File: rtl/stream_fifo2.sv
// ============================================================================
//  Module      : stream_fifo2
//  Description : Two-entry FIFO of pixel beats. Push and pop in the same
//                cycle on a full FIFO is accepted and keeps it full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module stream_fifo2
    import cnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pix_beat_t  push_beat,
    input  logic       pop,
    output pix_beat_t  head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    pix_beat_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_do_pop;
    logic       w_do_push;

    // A pop frees its slot in time for a push on the same edge.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    // Entry storage, written at the tail pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_beat;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr ^ w_do_push;
            r_rd_ptr <= r_rd_ptr ^ w_do_pop;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pixel_streamer.sv
// ============================================================================
//  Module      : pixel_streamer
//  Description : Reads one H x W frame from a synchronous-read image memory
//                and streams it in raster order with sof/eol/eof markers,
//                tolerating downstream backpressure. Pulses done at frame end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pixel_streamer #(
    parameter int H      = cnn_pkg::IMG_H,
    parameter int W      = cnn_pkg::IMG_W,
    parameter int PIX_W  = cnn_pkg::PIX_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    pixel_streamer_if.master bus
);
    import cnn_pkg::*;

    localparam int                c_TOTAL    = H * W;
    localparam int                c_ROW_W    = (H > 1) ? $clog2(H) : 1;
    localparam int                c_COL_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(c_TOTAL - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE = c_ROW_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_ONE = c_COL_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(W - 1);

    stream_state_t      r_state;
    stream_state_t      w_state_nxt;

    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] r_col;

    // Read returning this cycle on mem_rdata, with its markers.
    logic               r_pend;
    logic               r_pend_sof;
    logic               r_pend_eol;
    logic               r_pend_eof;

    logic               r_done;

    logic               w_issue;
    logic               w_addr_clr;
    logic               w_done_nxt;
    logic               w_fire_last;
    logic               w_cur_sof;
    logic               w_cur_eol;
    logic               w_cur_eof;

    pix_beat_t          w_pend_beat;
    pix_beat_t          w_fifo_head;
    pix_beat_t          w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [1:0]         w_fifo_count;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_fifo_pop;
    logic [2:0]         w_occ;

    // Markers of the address currently being read.
    assign w_cur_sof   = (r_row == '0) && (r_col == '0);
    assign w_cur_eol   = (r_col == c_COL_LAST);
    assign w_cur_eof   = (r_addr == c_LAST);
    assign w_fire_last = r_rd_en && (r_addr == c_LAST);

    // Returning read data bypasses the FIFO when it is empty so the first
    // pixel is visible in the same cycle the memory delivers it.
    always_comb begin
        w_pend_beat      = '0;
        w_pend_beat.data = bus.mem_rdata;
        w_pend_beat.sof  = r_pend_sof;
        w_pend_beat.eol  = r_pend_eol;
        w_pend_beat.eof  = r_pend_eof;
        w_head           = w_fifo_empty ? w_pend_beat : w_fifo_head;
    end

    assign w_valid    = !w_fifo_empty || r_pend;
    assign w_pop      = w_valid && bus.pix_ready;
    assign w_fifo_pop = w_pop && !w_fifo_empty;
    // A returning beat consumed directly from the bypass never enters the FIFO.
    assign w_push     = r_pend && !(w_fifo_empty && bus.pix_ready);

    // Beats committed but not yet transferred, after this cycle's pop.
    assign w_occ = 3'(w_fifo_count) + 3'(r_pend) + 3'(r_rd_en) - 3'(w_pop);

    stream_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_beat (w_pend_beat),
        .pop       (w_fifo_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Frame sequencing: next state, read issue and done generation.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_addr_clr  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_clr  = 1'b1;
                    w_issue     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_fire_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_issue = !w_fifo_full && (w_occ < 3'd2);
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head.eof) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read strobe, address and raster counters; the address stops at the
    // last pixel instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_rd_en <= w_issue;
            if (w_addr_clr) begin
                r_addr <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (r_rd_en && !w_fire_last) begin
                r_addr <= r_addr + c_ADDR_ONE;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + c_ROW_ONE;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                end
            end
        end
    end

    // Markers follow their read through the memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_sof <= 1'b0;
            r_pend_eol <= 1'b0;
            r_pend_eof <= 1'b0;
        end else begin
            r_pend <= r_rd_en;
            if (r_rd_en) begin
                r_pend_sof <= w_cur_sof;
                r_pend_eol <= w_cur_eol;
                r_pend_eof <= w_cur_eof;
            end
        end
    end

    // One-cycle done pulse after the eof transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_addr;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_valid ? w_head.data : '0;
    assign bus.pix_sof   = w_valid && w_head.sof;
    assign bus.pix_eol   = w_valid && w_head.eol;
    assign bus.pix_eof   = w_valid && w_head.eof;

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
// ============================================================================
//  Module      : tb_pixel_streamer
//  Description : Self-checking bench for pixel_streamer: a 28x28 instance
//                plus 2x3 and 1x1 instances, each fed by a memory holding
//                mem[i] = i mod 256.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_streamer;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start_a;
    logic start_s;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   max_cnt  = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    pixel_streamer_if #(.PIX_W(8), .ADDR_W(10)) if_a ();
    pixel_streamer_if #(.PIX_W(8), .ADDR_W(10)) if_b ();
    pixel_streamer_if #(.PIX_W(8), .ADDR_W(10)) if_c ();

    pixel_streamer #(.H(28), .W(28), .PIX_W(8), .ADDR_W(10)) u_dut_a (
        .clk (clk), .rst (rst), .start (start_a),
        .busy (busy_a), .done (done_a), .bus (if_a.master)
    );
    pixel_streamer #(.H(2), .W(3), .PIX_W(8), .ADDR_W(10)) u_dut_b (
        .clk (clk), .rst (rst), .start (start_s),
        .busy (busy_b), .done (done_b), .bus (if_b.master)
    );
    pixel_streamer #(.H(1), .W(1), .PIX_W(8), .ADDR_W(10)) u_dut_c (
        .clk (clk), .rst (rst), .start (start_s),
        .busy (busy_c), .done (done_c), .bus (if_c.master)
    );

    // Synchronous-read image memories.
    always @(posedge clk) if (if_a.mem_rd_en) if_a.mem_rdata <= mem[if_a.mem_addr];
    always @(posedge clk) if (if_b.mem_rd_en) if_b.mem_rdata <= mem[if_b.mem_addr];
    always @(posedge clk) if (if_c.mem_rd_en) if_c.mem_rdata <= mem[if_c.mem_addr];

    // Largest buffer occupancy seen on the 28x28 instance.
    always @(negedge clk) begin
        if (int'(u_dut_a.u_fifo.count) > max_cnt) max_cnt = int'(u_dut_a.u_fifo.count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {data, sof, eol, eof} of beat k in an h x w frame.
    function automatic logic [10:0] exp_beat(input int k, input int h, input int w);
        logic [7:0] d;
        d = 8'(k % 256);
        return {d, k == 0, (k % w) == (w - 1), k == (h * w - 1)};
    endfunction

    // mode 0: ready=1, 1: ready 30%, 2: 50-cycle stall at beat 100,
    // 3: extra start at beat 300, 4: reset at beat 400.
    task automatic run_a(input int mode);
        int k, first_valid, first_xfer, last_xfer, stall_left, stall_rd;
        bit xfer, rdy, prev_eof, stall_done, restarted, finished;
        k = 0; first_valid = -1; first_xfer = 0; last_xfer = 0;
        stall_left = 0; stall_rd = 0;
        prev_eof = 0; stall_done = 0; restarted = 0; finished = 0;
        if_a.pix_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("launch_busy", busy_a, 1);
        check("launch_rd_en", if_a.mem_rd_en, 1);
        check("launch_addr", if_a.mem_addr, 0);
        check("launch_valid", if_a.pix_valid, 0);
        for (int cyc = 1; cyc < 6000; cyc++) begin
            start_a = 1'b0;
            if (mode == 4 && k == 400) begin
                rst = 1'b1;
                #1;
                check("rst_valid", if_a.pix_valid, 0);
                check("rst_busy", busy_a, 0);
                check("rst_rd_en", if_a.mem_rd_en, 0);
                check("rst_done", done_a, 0);
                tick();
                tick();
                rst = 1'b0;
                tick();
                check("rst_no_done", done_a, 0);
                check("rst_idle", busy_a, 0);
                return;
            end
            if (mode == 2 && !stall_done && stall_left == 0 && k == 100) stall_left = 50;
            case (mode)
                1:       rdy = ($urandom_range(0, 99) < 30);
                2:       rdy = (stall_left == 0);
                default: rdy = 1'b1;
            endcase
            if (mode == 3 && k == 300 && !restarted) begin
                start_a   = 1'b1;
                restarted = 1'b1;
            end
            if_a.pix_ready = rdy;
            if (stall_left > 0) begin
                if (if_a.mem_rd_en) stall_rd++;
                stall_left--;
                if (stall_left == 0) begin
                    stall_done = 1'b1;
                    check("stall_reads_le2", stall_rd <= 2, 1);
                end
            end
            if (if_a.pix_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    check("first_valid_cycle", cyc, 2);
                end
                check("beat", {if_a.pix_data, if_a.pix_sof, if_a.pix_eol, if_a.pix_eof},
                      exp_beat(k, 28, 28));
            end
            check("done_timing", done_a, prev_eof);
            if (done_a) begin
                check("frame_beats", k, 784);
                if (mode == 0) check("frame_span", last_xfer - first_xfer, 783);
                start_a = (mode == 0);
                tick();
                start_a = 1'b0;
                check("done_one_shot", done_a, 0);
                check("idle_after_done", busy_a, 0);
                finished = 1'b1;
                break;
            end
            xfer     = if_a.pix_valid && rdy;
            prev_eof = xfer && if_a.pix_eof;
            if (xfer) begin
                if (k == 0) first_xfer = cyc;
                if (if_a.pix_eof) last_xfer = cyc;
                k++;
            end
            tick();
        end
        check("frame_completed", finished, 1);
    endtask

    // Runs the 2x3 and 1x1 instances side by side with ready held high.
    task automatic run_small();
        int kb, kc, nb, nc;
        bit pb, pc, xb, xc;
        kb = 0; kc = 0; nb = 0; nc = 0; pb = 0; pc = 0;
        if_b.pix_ready = 1'b1;
        if_c.pix_ready = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (if_b.pix_valid)
                check("b_beat", {if_b.pix_data, if_b.pix_sof, if_b.pix_eol, if_b.pix_eof},
                      exp_beat(kb, 2, 3));
            if (if_c.pix_valid)
                check("c_beat", {if_c.pix_data, if_c.pix_sof, if_c.pix_eol, if_c.pix_eof},
                      exp_beat(kc, 1, 1));
            check("b_done_timing", done_b, pb);
            check("c_done_timing", done_c, pc);
            if (done_b) nb++;
            if (done_c) nc++;
            xb = if_b.pix_valid;
            xc = if_c.pix_valid;
            pb = xb && if_b.pix_eof;
            pc = xc && if_c.pix_eof;
            tick();
            if (xb) kb++;
            if (xc) kc++;
        end
        check("b_beats", kb, 6);
        check("b_done_count", nb, 1);
        check("c_beats", kc, 1);
        check("c_done_count", nc, 1);
        check("b_idle", busy_b, 0);
        check("c_idle", busy_c, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 256);
        rst            = 1'b1;
        start_a        = 1'b0;
        start_s        = 1'b0;
        if_a.pix_ready = 1'b0;
        if_b.pix_ready = 1'b0;
        if_c.pix_ready = 1'b0;
        tick();
        tick();
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_rd_en", if_a.mem_rd_en, 0);
        check("reset_addr", if_a.mem_addr, 0);
        check("reset_valid", if_a.pix_valid, 0);
        check("reset_data", if_a.pix_data, 0);
        check("reset_markers", {if_a.pix_sof, if_a.pix_eol, if_a.pix_eof}, 0);
        rst = 1'b0;
        tick();

        run_a(0);
        tick();
        run_a(1);
        check("fifo_max_le2", max_cnt <= 2, 1);
        tick();
        run_a(2);
        tick();
        run_a(3);
        tick();
        run_a(0);
        tick();
        run_a(4);
        tick();
        run_a(0);
        tick();
        run_small();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Transmit side of the CNN image input. It reads one H×W frame of pixels from a synchronous-read image memory and presents them in raster order on a valid/ready stream to the CNN datapath (`top`).
- It adds start-of-frame, end-of-line and end-of-frame markers, and emits a done pulse when the frame completes.
- It absorbs the memory's one-cycle read latency and downstream backpressure without dropping or duplicating pixels.

Parameters:
- H, 28, image rows
- W, 28, image columns
- PIX_W, 8, pixel width in bits
- ADDR_W, 10, memory address width; must satisfy 2^ADDR_W ≥ H*W

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until the done pulse
- done  out  1  one-cycle pulse when the last pixel has been accepted
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address, row*W+col
- mem_rdata  in  PIX_W  read data, valid on the cycle after mem_rd_en
- pix_data  out  PIX_W  pixel value
- pix_valid  out  1  pixel present on the stream
- pix_ready  in  1  downstream accepts the pixel
- pix_sof  out  1  first pixel of the frame, (0,0)
- pix_eol  out  1  last pixel of a row, col==W-1
- pix_eof  out  1  last pixel of the frame, (H-1,W-1)

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; address counter 0; buffer empty; outstanding-read flag 0. Reset mid-frame abandons the frame immediately, with no done pulse; pix_valid drops in the same cycle.
- A transfer occurs on a rising edge where pix_valid && pix_ready are both high.
- FSM states:
  - IDLE: on start=1, go to FETCH and clear the read address to 0.
  - FETCH: issue reads until H*W addresses are issued, then go to DRAIN.
  - DRAIN: wait for the buffer to empty and the final transfer (pix_eof) to complete, then go to IDLE with done=1 for exactly one cycle.
- busy=1 in FETCH and DRAIN. start is ignored while busy=1 and during the done cycle.
- Read issue:
  - mem_rd_en is registered and may be high only in FETCH.
  - A read is issued in a cycle only if (buffered entries + outstanding read + pending pop) leaves room in the 2-entry buffer; pops in the current cycle count as freed space.
  - mem_addr increments by 1 per issued read, from 0 to H*W-1, never wrapping inside a frame.
- Buffer: a 2-entry FIFO. Each entry holds pixel data and its sof/eol/eof bits, computed from the issued address's row/col counters and pipelined alongside the read.
  - Data is captured one cycle after mem_rd_en.
  - Head entry drives pix_data and the marker outputs; pix_valid = not empty.
- Stability: while pix_valid=1 and pix_ready=0, pix_data and all markers must hold stable.
- Simultaneous push and pop on a full buffer is legal and keeps the count at 2. It must not overflow.
- Latency:
  - start sampled at edge N → mem_rd_en=1 with addr 0 in cycle N+1 → pix_valid=1 in cycle N+2.
  - With pix_ready held at 1, a frame takes H*W consecutive transfer cycles, so first-to-last is H*W-1 cycles.
  - done is high in the cycle after the eof transfer edge.
- Counters: row and column counters are used for markers, with col wrapping at W-1 and row incrementing on wrap. Width is $clog2 of each dimension.
- H=1 or W=1 are legal. With H*W=1, sof, eol and eof are all set on the single pixel.

Decomposition:
- cnn_pkg holds:
  - the shared constants IMG_H=28, IMG_W=28 and PIX_W=8;
  - ADDR_W = $clog2(IMG_H*IMG_W);
  - a packed struct pix_beat_t {data, sof, eol, eof}.
- One sub-module: stream_fifo2, the 2-entry FIFO for pix_beat_t with push, pop, full, empty and count outputs.
- The FSM, counters and read-issue logic stay in pixel_streamer.

Test Plan:
- Memory preloaded with mem[i]=i mod 256; start once; pix_ready=1 → 784 transfers with data 0,1,…,255,0,…; sof only on beat 0; eol on beats 27, 55, …, 783; eof only on beat 783; pix_valid first high 2 cycles after start; done pulses 1 cycle after beat 783; busy low afterwards.
- Random pix_ready at 30% high for a full frame → exactly 784 transfers in order with no duplicates; pix_data is stable across every valid&&!ready cycle; buffer never exceeds 2 entries (assertion).
- pix_ready=0 for 50 cycles starting at beat 100 → mem_rd_en stops after at most 2 further reads; pix_data stays 100; stream resumes with 100, 101, …
- start pulsed again at beat 300 → ignored; frame ends at beat 783 with a single done pulse; a new start after done produces a fresh frame beginning at data 0 with sof.
- rst asserted asynchronously mid-frame at beat 400 → pix_valid, busy and mem_rd_en go 0 immediately with no done pulse; after rst deasserts, a start streams from address 0.
- Parameters H=2, W=3 → 6 beats; eol on beats 2 and 5; eof on beat 5.
- Parameters H=1, W=1 → a single beat with sof=eol=eof=1 and a done pulse.
